muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : RV32M operation encodings, FSM state type, operand sign helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // MUL only keeps the low half, which is sign-independent, so it runs unsigned.
  function automatic logic a_is_signed(input logic [2:0] f);
    return !((f == F_MUL) || (f == F_MULHU) || (f == F_DIVU) || (f == F_REMU));
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return !((f == F_MUL) || (f == F_MULHSU) || (f == F_MULHU) ||
             (f == F_DIVU) || (f == F_REMU));
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one shift-add multiply or restoring-divide bit step
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    addend  = lo_i[0] ? opnd_i : '0;
    sum     = {1'b0, acc_i} + {1'b0, addend};
    shifted = {acc_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    // When ge holds the true difference is below 2^WIDTH, so the low bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = ge ? diff : shifted[WIDTH-1:0];
      lo_o  = {lo_i[WIDTH-2:0], ge};
    end else begin
      acc_o = sum[WIDTH:1];
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit, one bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  input  logic             flush
);

  localparam int               CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       func_q, func_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;

  logic             a_neg, b_neg, div_zero, div_ovf, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;
  logic [WIDTH-1:0] step_acc, step_lo, quo_fix, rem_fix, calc_res;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg    = a_is_signed(func3) && op_a[WIDTH-1];
  assign b_neg    = b_is_signed(func3) && op_b[WIDTH-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign neg_in   = (func3 == F_REM) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = func3[2] && (op_b == '0);
  assign div_ovf  = ((func3 == F_DIV) || (func3 == F_REM)) &&
                    (op_a == MIN_NEG) && (op_b == '1);
  assign special_res = div_zero ? (((func3 == F_DIV) || (func3 == F_DIVU)) ? '1 : op_a)
                                : ((func3 == F_DIV) ? op_a : '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (func_q[2]),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  // Sign correction is taken straight off the final step so DONE costs no cycle.
  assign prod     = {step_acc, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = neg_q ? -step_acc : step_acc;
  assign calc_res = func_q[2] ? (func_q[1] ? rem_fix : quo_fix)
                              : ((func_q == F_MUL) ? prod_fix[WIDTH-1:0]
                                                   : prod_fix[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            func_d = func3;
            neg_d  = neg_in;
            acc_d  = '0;
            lo_d   = func3[2] ? a_mag : b_mag;
            opnd_d = func3[2] ? b_mag : a_mag;
            cnt_d  = '0;
            if (div_zero || div_ovf) begin
              res_d   = special_res;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          if (cnt_q == LAST) begin
            res_d   = calc_res;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = out_valid ? res_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vector bench for muldiv_unit at WIDTH=32
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;
  logic        flush = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func3     (func3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // lat = posedges after the accept edge before out_valid is seen (0: next cycle).
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; func3 = f; op_a = a; op_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    if (lat > 0) check({nm, "_calc"}, {busy, out_valid, result}, {1'b1, 1'b0, 32'h0});
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_lat"}, 64'(n), 64'(lat));
    check({nm, "_res"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       32};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        32};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        0};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vecs[12] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    vecs[13] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32};
    vecs[14] = '{3'b011, 32'h00010000, 32'h00010000, 32'd1,        32};
    vecs[15] = '{3'b000, 32'h00010000, 32'h00010003, 32'h00030000, 32};
    vecs[16] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32};
    vecs[17] = '{3'b111, 32'h80000001, 32'h10,       32'd1,        32};

    #12;
    check("reset_outputs", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result and in_ready held while the consumer stalls.
    @(negedge clk);
    in_valid = 1'b1; func3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    held = result;
    check("bp_first", held, 32'hFFFFFFEB);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_result", result, 32'hFFFFFFEB);
      check("bp_ready", {in_ready, out_valid}, {1'b0, 1'b1});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {in_ready, busy}, {1'b1, 1'b0});

    // Flush mid-CALC with a competing request, then flush while IDLE.
    @(negedge clk);
    in_valid = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("flush_calc", {in_ready, busy, out_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    @(posedge clk); #1;
    check("flush_idle_noacc", {in_ready, busy}, {1'b1, 1'b0});
    flush = 1'b0; in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) n++;
    end
    check("flush_no_result", 64'(n), 64'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    in_valid = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 arst_n = 1'b0;
    #1 check("areset_mid", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    arst_n = 1'b1;
    run_op("post_reset", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
